// File: rtl/uop_sequencer_pkg.sv
// Shared encodings for the uop sequencer: sequencing-op field, FSM states
// and default ROM geometry.
package uop_sequencer_pkg;

  localparam int DEF_UOP_BUF_SIZE  = 256;
  localparam int DEF_UOP_BUF_WIDTH = 64;
  localparam int DEF_RSTACK_DEPTH  = 4;
  localparam int DEF_RESET_VECTOR  = 0;

  // Sequencing op lives in the top SEQ_OP_W bits; target follows directly below.
  localparam int SEQ_OP_W = 3;

  typedef enum logic [SEQ_OP_W-1:0] {
    OP_NEXT = 3'b000,
    OP_JUMP = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011,
    OP_HALT = 3'b100
  } seq_op_e;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

// File: rtl/uop_rstack.sv
// Return-address stack for the uop sequencer; only built when
// UOP_SEQ_RSTACK_EN is defined. Clear has priority over push/pop.
`ifdef UOP_SEQ_RSTACK_EN
module uop_rstack #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   cnt;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  assign wr_idx  = cnt[PW-1:0];
  assign top_idx = wr_idx - 1'b1;
  assign full    = (cnt == DEPTH[PW:0]);
  assign empty   = (cnt == '0);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= data;
      cnt         <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uop_sequencer.sv
// Microcode sequencer: drives the uop ROM address, decodes sequencing ops and
// delivers uops over valid/stall. Return stack enabled by UOP_SEQ_RSTACK_EN.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_RUN  | fetching sequentially, decoding accepted responses
// ST_HALT | HALT delivered, fetch idle until redirect/reset
// ST_ERR  | stack over/underflow or illegal op, output idle
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_BUF_SIZE  = DEF_UOP_BUF_SIZE,
  parameter int UOP_BUF_WIDTH = DEF_UOP_BUF_WIDTH,
  parameter int RSTACK_DEPTH  = DEF_RSTACK_DEPTH,
  parameter int RESET_VECTOR  = DEF_RESET_VECTOR,
  localparam int AW = $clog2(UOP_BUF_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AW-1:0]            uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0] uop,
  input  logic                     next_stalled,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_addr,
  output logic                     out_valid,
  output logic [UOP_BUF_WIDTH-1:0] out_uop,
  output logic [AW-1:0]            out_pc,
  output logic                     halted,
  output logic                     seq_error
);

  if (RSTACK_DEPTH < 2 || (RSTACK_DEPTH & (RSTACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RSTACK_DEPTH must be a power of two, at least 2");
  end

  logic [1:0]               state;
  logic [AW-1:0]            fa;
  logic                     rsp_valid;
  logic [AW-1:0]            rsp_pc;
  logic                     skid_valid;
  logic [UOP_BUF_WIDTH-1:0] skid_uop;
  logic [AW-1:0]            skid_pc;

  logic                     src_valid;
  logic [UOP_BUF_WIDTH-1:0] src_uop;
  logic [AW-1:0]            src_pc;
  logic                     out_free;
  logic                     accept;
  logic                     fetch_en;
  seq_op_e                  op;
  logic [AW-1:0]            jump_tgt;
  logic [AW-1:0]            next_fa;
  logic                     deliver;
  logic                     take;
  logic                     go_halt;
  logic                     go_err;

  // The skid entry, when present, is always older than any ROM response.
  assign src_valid = skid_valid | rsp_valid;
  assign src_uop   = skid_valid ? skid_uop : uop;
  assign src_pc    = skid_valid ? skid_pc  : rsp_pc;

  assign out_free = !out_valid || !next_stalled;
  assign accept   = (state == ST_RUN) && src_valid && out_free;
  assign op       = seq_op_e'(src_uop[UOP_BUF_WIDTH-1 -: SEQ_OP_W]);
  assign jump_tgt = src_uop[UOP_BUF_WIDTH-SEQ_OP_W-1 -: AW];

  // Stop fetching once a response would have nowhere to land next cycle.
  assign fetch_en = (state == ST_RUN) && (out_free || (!skid_valid && !rsp_valid));

`ifdef UOP_SEQ_RSTACK_EN
  logic          rs_push;
  logic          rs_pop;
  logic [AW-1:0] rs_top;
  logic          rs_full;
  logic          rs_empty;

  uop_rstack #(
    .DEPTH (RSTACK_DEPTH),
    .DW    (AW)
  ) u_rstack (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (rs_push),
    .pop   (rs_pop),
    .data  (src_pc + 1'b1),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty)
  );
`endif

  always_comb begin
    deliver = 1'b0;
    take    = 1'b0;
    go_halt = 1'b0;
    go_err  = 1'b0;
    next_fa = jump_tgt;
`ifdef UOP_SEQ_RSTACK_EN
    rs_push = 1'b0;
    rs_pop  = 1'b0;
`endif
    if (accept) begin
      case (op)
        OP_NEXT: deliver = 1'b1;
        OP_JUMP: begin
          deliver = 1'b1;
          take    = 1'b1;
        end
`ifdef UOP_SEQ_RSTACK_EN
        OP_CALL: begin
          if (rs_full) begin
            go_err = 1'b1;
          end else begin
            deliver = 1'b1;
            take    = 1'b1;
            rs_push = 1'b1;
          end
        end
        OP_RET: begin
          if (rs_empty) begin
            go_err = 1'b1;
          end else begin
            deliver = 1'b1;
            take    = 1'b1;
            rs_pop  = 1'b1;
            next_fa = rs_top;
          end
        end
`endif
        OP_HALT: begin
          deliver = 1'b1;
          go_halt = 1'b1;
        end
        default: go_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      fa         <= RESET_VECTOR[AW-1:0];
      rsp_valid  <= 1'b0;
      rsp_pc     <= '0;
      skid_valid <= 1'b0;
      skid_uop   <= '0;
      skid_pc    <= '0;
      out_valid  <= 1'b0;
      out_uop    <= '0;
      out_pc     <= '0;
    end else if (redirect_valid) begin
      state      <= ST_RUN;
      fa         <= redirect_addr;
      rsp_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      // Any flow change squashes the wrong-path fetch issued this cycle.
      if (go_err) begin
        state     <= ST_ERR;
        rsp_valid <= 1'b0;
      end else if (go_halt) begin
        state     <= ST_HALT;
        rsp_valid <= 1'b0;
      end else if (take) begin
        fa        <= next_fa;
        rsp_valid <= 1'b0;
      end else begin
        rsp_valid <= fetch_en;
        rsp_pc    <= fa;
        if (fetch_en) fa <= fa + 1'b1;
      end

      if (out_free) begin
        skid_valid <= 1'b0;
      end else if (rsp_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_uop   <= uop;
        skid_pc    <= rsp_pc;
      end

      if (out_free) begin
        out_valid <= deliver;
        if (deliver) begin
          out_uop <= src_uop;
          out_pc  <= src_pc;
        end
      end
    end
  end

  assign uop_addr  = fa;
  assign halted    = (state == ST_HALT);
  assign seq_error = (state == ST_ERR);

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer with a synchronous-read ROM model; CALL/RET
// expectations follow UOP_SEQ_RSTACK_EN.
module tb_uop_sequencer;
  import uop_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  uop_addr;
  logic [63:0] rom_q;
  logic        next_stalled;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic [63:0] out_uop;
  logic [7:0]  out_pc;
  logic        halted;
  logic        seq_error;

  logic [63:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[uop_addr];

  uop_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .uop_addr       (uop_addr),
    .uop            (rom_q),
    .next_stalled   (next_stalled),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_uop        (out_uop),
    .out_pc         (out_pc),
    .halted         (halted),
    .seq_error      (seq_error)
  );

  function automatic logic [63:0] mk(input logic [2:0] op, input logic [7:0] tgt,
                                     input logic [7:0] tag);
    return {op, tgt, 45'd0, tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] pc);
    chk(tag, {out_valid, out_pc}, {1'b1, pc});
  endtask

  task automatic chk_gap(input string tag);
    chk(tag, out_valid, 1'b0);
  endtask

  task automatic redirect(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(OP_NEXT, 8'h00, i[7:0]);
    rom[8'h05] = mk(OP_JUMP, 8'h20, 8'h05);
    rom[8'h22] = mk(OP_HALT, 8'h00, 8'h22);
    rom[8'h51] = mk(OP_CALL, 8'h60, 8'h51);
    rom[8'h61] = mk(OP_RET,  8'h00, 8'h61);
    rom[8'h54] = mk(OP_RET,  8'h00, 8'h54);
    for (int i = 0; i < 5; i++) rom[8'h70 + i] = mk(OP_CALL, 8'h71 + i[7:0], 8'h70 + i[7:0]);
    rom[8'h80] = mk(3'b101, 8'h00, 8'h80);

    reset = 1'b0; next_stalled = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_addr", uop_addr, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_uop", out_uop, 64'h0);
    chk("rst_pc", out_pc, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", seq_error, 1'b0);
    tick();
    chk_gap("first_gap");

    // sequential stream then JUMP 0x20 with one bubble, then HALT at 0x22
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_pc("seq", i[7:0]);
    end
    tick();
    chk_pc("jump_src", 8'h05);
    chk("jump_uop", out_uop, mk(OP_JUMP, 8'h20, 8'h05));
    chk("jump_addr", uop_addr, 8'h20);
    tick(); chk_gap("jump_bubble");
    tick(); chk_pc("jump_tgt", 8'h20);
    tick(); chk_pc("jump_tgt1", 8'h21);
    tick(); chk_pc("halt_pc", 8'h22);
    chk("halt_flag", halted, 1'b1);
    chk("halt_addr", uop_addr, 8'h23);
    tick(); chk_gap("halt_idle");
    chk("halt_flag2", halted, 1'b1);
    chk("halt_addr2", uop_addr, 8'h23);

    // redirect out of HALT, then a 3-cycle stall on 0x37
    redirect(8'h30);
    chk("redir_addr", uop_addr, 8'h30);
    chk("redir_halt_clr", halted, 1'b0);
    chk_gap("redir_gap1");
    tick(); chk_gap("redir_gap2");
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_pc("stream30", 8'h30 + i[7:0]);
    end
    tick(); chk_pc("stall_hold0", 8'h37);
    next_stalled = 1'b1;
    tick(); chk_pc("stall_hold1", 8'h37); chk("stall_addr1", uop_addr, 8'h39);
    tick(); chk_pc("stall_hold2", 8'h37); chk("stall_addr2", uop_addr, 8'h39);
    tick(); next_stalled = 1'b0; chk_pc("stall_hold3", 8'h37);
    tick(); chk_pc("stall_rel0", 8'h38);
    tick(); chk_pc("stall_rel1", 8'h39);
    tick(); chk_pc("stall_rel2", 8'h3a);

    // redirect and stall together: redirect wins
    next_stalled = 1'b1;
    redirect(8'h50);
    next_stalled = 1'b0;
    chk_gap("rs_gap1");
    chk("rs_addr", uop_addr, 8'h50);
    tick(); chk_gap("rs_gap2");
    tick(); chk_pc("rs_first", 8'h50);
    tick();
`ifdef UOP_SEQ_RSTACK_EN
    chk_pc("call_pc", 8'h51);
    tick(); chk_gap("call_bubble");
    tick(); chk_pc("call_tgt", 8'h60);
    tick(); chk_pc("ret_pc", 8'h61);
    tick(); chk_gap("ret_bubble");
    tick(); chk_pc("ret_tgt", 8'h52);
    tick(); chk_pc("ret_tgt1", 8'h53);
    chk("ret_err_pre", seq_error, 1'b0);
    tick(); chk_gap("underflow_gap");
    chk("underflow_err", seq_error, 1'b1);

    // five nested calls overflow a 4-deep stack
    redirect(8'h70);
    tick();
    tick(); chk_pc("nest0", 8'h70);
    tick(); chk_gap("nest_b0");
    tick(); chk_pc("nest1", 8'h71);
    tick(); chk_gap("nest_b1");
    tick(); chk_pc("nest2", 8'h72);
    tick(); chk_gap("nest_b2");
    tick(); chk_pc("nest3", 8'h73);
    tick(); chk_gap("nest_b3");
    chk("nest_err_pre", seq_error, 1'b0);
    tick(); chk_gap("overflow_gap");
    chk("overflow_err", seq_error, 1'b1);
`else
    chk_gap("call_illegal_gap");
    chk("call_illegal_err", seq_error, 1'b1);
`endif

    // redirect clears the error
    redirect(8'h10);
    chk("recover_err", seq_error, 1'b0);
    chk_gap("recover_gap1");
    tick();
    tick(); chk_pc("recover_pc", 8'h10);
    tick(); chk_pc("recover_pc1", 8'h11);

    // illegal op 101
    redirect(8'h80);
    tick(); chk_gap("illegal_gap0"); chk("illegal_err_pre", seq_error, 1'b0);
    tick(); chk_gap("illegal_gap"); chk("illegal_err", seq_error, 1'b1);

    // halt again, then reset (with a redirect that must be ignored)
    redirect(8'h22);
    tick();
    tick(); chk_pc("halt2_pc", 8'h22);
    chk("halt2_flag", halted, 1'b1);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    tick();
    chk("rst2_addr", uop_addr, 8'h00);
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_err", seq_error, 1'b0);
    chk_gap("rst2_valid");
    chk("rst2_pc", out_pc, 8'h00);
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick(); chk_gap("rst2_gap");
    tick(); chk_pc("rst2_first", 8'h00);
    tick(); chk_pc("rst2_second", 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
